// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single processor-memory port between committing
// stores (ST), load execution (LD) and instruction fetch (IF).
// Fixed priority ST > LD > IF. LD and IF are gated by the count of loads in flight.
// A per-tag owner table routes returned data back to LD or IF.
// Optional feature: define MEM_ARB_STARVE_EN to boost IF after STARVE_LIMIT
// consecutive lost decisions.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 64,
  parameter int TAG_W           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_grant,
  output logic              st_done,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_grant,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic [DATA_W-1:0] resp_data,
  output logic              ld_resp_valid,
  output logic              if_resp_valid,
  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [DATA_W-1:0] proc2mem_data,
  input  logic [TAG_W-1:0]  mem2proc_response,
  input  logic [TAG_W-1:0]  mem2proc_tag,
  input  logic [DATA_W-1:0] mem2proc_data,
  output logic              commit_wr_mem,
  output logic              ex_rd_mem
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int NTAG  = 2 ** TAG_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] outstanding;
  logic [NTAG-1:0]  tbl_valid;
  logic [NTAG-1:0]  tbl_owner;    // 1 = IF, 0 = LD
  logic             cur_owner;    // owner of the load currently being issued
  logic             win_st;
  logic             win_ld;
  logic             win_if;
  logic             rd_ok;
  logic             accepted;
  logic             load_accept;
  logic             ret_hit;
  logic             if_boost;

  assign rd_ok       = (outstanding < MAX_CNT);
  assign accepted    = (mem2proc_response != {TAG_W{1'b0}});
  assign load_accept = (state == ISSUE) && accepted && (proc2mem_command == CMD_LOAD);
  assign ret_hit     = (mem2proc_tag != {TAG_W{1'b0}}) && tbl_valid[mem2proc_tag];

`ifdef MEM_ARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_LIMIT = SC_W'(STARVE_LIMIT);
  localparam logic [SC_W-1:0] SC_ONE   = {{(SC_W-1){1'b0}}, 1'b1};
  logic [SC_W-1:0] starve_cnt;

  assign if_boost = (starve_cnt >= SC_LIMIT);

  // Count IDLE decisions in which a waiting fetch lost; clear when fetch wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= {SC_W{1'b0}};
    end else if (win_if) begin
      starve_cnt <= {SC_W{1'b0}};
    end else if (if_req && (win_st || win_ld) && (starve_cnt < SC_LIMIT)) begin
      starve_cnt <= starve_cnt + SC_ONE;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end
`else
  assign if_boost = 1'b0;
`endif

  // Arbitration and next-state decision.
  always_comb begin
    win_st     = 1'b0;
    win_ld     = 1'b0;
    win_if     = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (if_boost && if_req && rd_ok) begin
          win_if = 1'b1;
        end else if (st_req) begin
          win_st = 1'b1;
        end else if (ld_req && rd_ok) begin
          win_ld = 1'b1;
        end else if (if_req && rd_ok) begin
          win_if = 1'b1;
        end else begin
          win_st = 1'b0;
        end
        if (win_st || win_ld || win_if) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        if (accepted) begin
          state_next = IDLE;
        end else begin
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the winning command and drive grants, done pulse and hazard flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_grant         <= 1'b0;
      ld_grant         <= 1'b0;
      if_grant         <= 1'b0;
      st_done          <= 1'b0;
      proc2mem_command <= CMD_NONE;
      proc2mem_addr    <= {ADDR_W{1'b0}};
      proc2mem_data    <= {DATA_W{1'b0}};
      cur_owner        <= 1'b0;
      commit_wr_mem    <= 1'b0;
      ex_rd_mem        <= 1'b0;
    end else begin
      st_grant <= win_st;
      ld_grant <= win_ld;
      if_grant <= win_if;
      st_done  <= (state == ISSUE) && accepted && (proc2mem_command == CMD_STORE);
      if (win_st) begin
        proc2mem_command <= CMD_STORE;
        proc2mem_addr    <= st_addr;
        proc2mem_data    <= st_data;
        commit_wr_mem    <= 1'b1;
      end else if (win_ld) begin
        proc2mem_command <= CMD_LOAD;
        proc2mem_addr    <= ld_addr;
        proc2mem_data    <= {DATA_W{1'b0}};
        cur_owner        <= 1'b0;
        ex_rd_mem        <= 1'b1;
      end else if (win_if) begin
        proc2mem_command <= CMD_LOAD;
        proc2mem_addr    <= if_addr;
        proc2mem_data    <= {DATA_W{1'b0}};
        cur_owner        <= 1'b1;
      end else if ((state == ISSUE) && accepted) begin
        proc2mem_command <= CMD_NONE;
        commit_wr_mem    <= 1'b0;
        ex_rd_mem        <= 1'b0;
      end else begin
        proc2mem_command <= proc2mem_command;
      end
    end
  end

  // Owner table, in-flight counter and return-data routing; a new entry beats a same-tag retire.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tbl_valid     <= {NTAG{1'b0}};
      tbl_owner     <= {NTAG{1'b0}};
      outstanding   <= {CNT_W{1'b0}};
      resp_data     <= {DATA_W{1'b0}};
      ld_resp_valid <= 1'b0;
      if_resp_valid <= 1'b0;
    end else begin
      ld_resp_valid <= 1'b0;
      if_resp_valid <= 1'b0;
      if (ret_hit) begin
        resp_data               <= mem2proc_data;
        ld_resp_valid           <= ~tbl_owner[mem2proc_tag];
        if_resp_valid           <= tbl_owner[mem2proc_tag];
        tbl_valid[mem2proc_tag] <= 1'b0;
      end else begin
        resp_data <= resp_data;
      end
      if (load_accept) begin
        tbl_valid[mem2proc_response] <= 1'b1;
        tbl_owner[mem2proc_response] <= cur_owner;
      end else begin
        tbl_owner <= tbl_owner;
      end
      case ({load_accept, ret_hit})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default parameters).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        st_req = 1'b0, ld_req = 1'b0, if_req = 1'b0;
  logic [31:0] st_addr = 32'd0, ld_addr = 32'd0, if_addr = 32'd0;
  logic [63:0] st_data = 64'd0;
  logic        st_grant, st_done, ld_grant, if_grant;
  logic [63:0] resp_data;
  logic        ld_resp_valid, if_resp_valid;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response = 4'd0, mem2proc_tag = 4'd0;
  logic [63:0] mem2proc_data = 64'd0;
  logic        commit_wr_mem, ex_rd_mem;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter dut (
    .clock(clock), .reset(reset),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data),
    .st_grant(st_grant), .st_done(st_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_grant(ld_grant),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
    .resp_data(resp_data), .ld_resp_valid(ld_resp_valid), .if_resp_valid(if_resp_valid),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag),
    .mem2proc_data(mem2proc_data),
    .commit_wr_mem(commit_wr_mem), .ex_rd_mem(ex_rd_mem)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    st_req = 1'b0; ld_req = 1'b0; if_req = 1'b0;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
  endtask

  // Issue one load from LD or IF and have memory accept it with tag t; reports whether it was granted.
  task automatic do_load(input bit use_if, input logic [31:0] a, input logic [3:0] t, output bit got);
    if (use_if) begin if_req = 1'b1; if_addr = a; end
    else begin ld_req = 1'b1; ld_addr = a; end
    cyc();
    got = use_if ? if_grant : ld_grant;
    ld_req = 1'b0; if_req = 1'b0;
    if (got) begin
      mem2proc_response = t;
      cyc();
      mem2proc_response = 4'd0;
    end
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    apply_reset();
    obs = {st_grant, st_done, ld_grant, if_grant, ld_resp_valid, if_resp_valid,
           commit_wr_mem, ex_rd_mem, proc2mem_command};
    vectors++;
    if (obs !== 10'd0 || resp_data !== 64'd0 || proc2mem_addr !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got flags=%b addr=%h data=%h, want all zero", obs, proc2mem_addr, resp_data);
    end
  endtask

  task automatic test_lone_fetch();
    apply_reset();
    if_req = 1'b1; if_addr = 32'h100;
    cyc();
    vectors++;
    if (if_grant !== 1'b1 || proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL fetch_grant: grant=%b cmd=%0d addr=%h, want 1 1 100", if_grant, proc2mem_command, proc2mem_addr);
    end
    if_req = 1'b0;
    cyc();
    vectors++;
    if (if_grant !== 1'b0 || proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL fetch_hold: grant=%b cmd=%0d addr=%h, want 0 1 100", if_grant, proc2mem_command, proc2mem_addr);
    end
    mem2proc_response = 4'd3;
    cyc();
    mem2proc_response = 4'd0;
    vectors++;
    if (proc2mem_command !== 2'd0) begin
      miscompares++;
      $display("FAIL fetch_cmd_clear: cmd=%0d, want 0", proc2mem_command);
    end
    mem2proc_tag = 4'd3; mem2proc_data = 64'hAB;
    cyc();
    mem2proc_tag = 4'd0;
    vectors++;
    if (if_resp_valid !== 1'b1 || ld_resp_valid !== 1'b0 || resp_data !== 64'hAB) begin
      miscompares++;
      $display("FAIL fetch_return: if_v=%b ld_v=%b data=%h, want 1 0 ab", if_resp_valid, ld_resp_valid, resp_data);
    end
    cyc();
    vectors++;
    if (if_resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_return_pulse: if_v=%b, want 0", if_resp_valid);
    end
  endtask

  task automatic test_priority();
    apply_reset();
    st_req = 1'b1; st_addr = 32'h40; st_data = 64'h1234;
    ld_req = 1'b1; ld_addr = 32'h80;
    if_req = 1'b1; if_addr = 32'hC0;
    cyc();
    vectors++;
    if ({st_grant, ld_grant, if_grant} !== 3'b100 || commit_wr_mem !== 1'b1 || ex_rd_mem !== 1'b0 ||
        proc2mem_command !== 2'd2 || proc2mem_addr !== 32'h40 || proc2mem_data !== 64'h1234) begin
      miscompares++;
      $display("FAIL prio_store: g=%b wr=%b rd=%b cmd=%0d addr=%h data=%h, want 100 1 0 2 40 1234",
               {st_grant, ld_grant, if_grant}, commit_wr_mem, ex_rd_mem, proc2mem_command, proc2mem_addr, proc2mem_data);
    end
    st_req = 1'b0; mem2proc_response = 4'd1;
    cyc();
    mem2proc_response = 4'd0;
    vectors++;
    if (st_done !== 1'b1 || commit_wr_mem !== 1'b0 || proc2mem_command !== 2'd0) begin
      miscompares++;
      $display("FAIL prio_st_done: done=%b wr=%b cmd=%0d, want 1 0 0", st_done, commit_wr_mem, proc2mem_command);
    end
    cyc();
    vectors++;
    if ({st_grant, ld_grant, if_grant} !== 3'b010 || ex_rd_mem !== 1'b1 || st_done !== 1'b0 || proc2mem_addr !== 32'h80) begin
      miscompares++;
      $display("FAIL prio_load: g=%b rd=%b done=%b addr=%h, want 010 1 0 80",
               {st_grant, ld_grant, if_grant}, ex_rd_mem, st_done, proc2mem_addr);
    end
    ld_req = 1'b0; mem2proc_response = 4'd2;
    cyc();
    mem2proc_response = 4'd0;
    vectors++;
    if (ex_rd_mem !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_rd_clear: rd=%b, want 0", ex_rd_mem);
    end
    cyc();
    vectors++;
    if ({st_grant, ld_grant, if_grant} !== 3'b001 || ex_rd_mem !== 1'b0 || proc2mem_addr !== 32'hC0) begin
      miscompares++;
      $display("FAIL prio_fetch: g=%b rd=%b addr=%h, want 001 0 c0", {st_grant, ld_grant, if_grant}, ex_rd_mem, proc2mem_addr);
    end
    if_req = 1'b0; mem2proc_response = 4'd4;
    cyc();
    mem2proc_response = 4'd0;
    mem2proc_tag = 4'd2; mem2proc_data = 64'h22;
    cyc();
    vectors++;
    if (ld_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || resp_data !== 64'h22) begin
      miscompares++;
      $display("FAIL prio_ld_route: ld_v=%b if_v=%b data=%h, want 1 0 22", ld_resp_valid, if_resp_valid, resp_data);
    end
    mem2proc_tag = 4'd4; mem2proc_data = 64'h44;
    cyc();
    mem2proc_tag = 4'd0;
    vectors++;
    if (ld_resp_valid !== 1'b0 || if_resp_valid !== 1'b1 || resp_data !== 64'h44) begin
      miscompares++;
      $display("FAIL prio_if_route: ld_v=%b if_v=%b data=%h, want 0 1 44", ld_resp_valid, if_resp_valid, resp_data);
    end
  endtask

  task automatic test_outstanding_limit();
    bit got;
    bit seen;
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      do_load(1'b0, 32'h1000 + 32'(i), 4'(i), got);
      vectors++;
      if (got !== 1'b1) begin
        miscompares++;
        $display("FAIL limit_load_%0d: grant=%b, want 1", i, got);
      end
    end
    ld_req = 1'b1; ld_addr = 32'h2000;
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++;
      if (ld_grant !== 1'b0 || proc2mem_command !== 2'd0) begin
        miscompares++;
        $display("FAIL limit_blocked: grant=%b cmd=%0d, want 0 0", ld_grant, proc2mem_command);
      end
    end
    mem2proc_tag = 4'd2; mem2proc_data = 64'h2;
    cyc();
    mem2proc_tag = 4'd0;
    vectors++;
    if (ld_resp_valid !== 1'b1 || resp_data !== 64'h2) begin
      miscompares++;
      $display("FAIL limit_return: ld_v=%b data=%h, want 1 2", ld_resp_valid, resp_data);
    end
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      if (ld_grant === 1'b1) seen = 1'b1;
      else cyc();
    end
    if (ld_grant === 1'b1) seen = 1'b1;
    vectors++;
    if (seen !== 1'b1) begin
      miscompares++;
      $display("FAIL limit_regrant: grant seen=%b, want 1 within 2 cycles", seen);
    end
    ld_req = 1'b0;
    if (seen) begin
      mem2proc_response = 4'd2;
      cyc();
      mem2proc_response = 4'd0;
    end
  endtask

  task automatic test_same_tag_accept_return();
    bit got;
    logic [3:0] tags [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8};
    apply_reset();
    do_load(1'b0, 32'h200, 4'd5, got);
    if_req = 1'b1; if_addr = 32'h300;
    cyc();
    vectors++;
    if (if_grant !== 1'b1) begin
      miscompares++;
      $display("FAIL same_tag_grant: if_grant=%b, want 1", if_grant);
    end
    if_req = 1'b0;
    mem2proc_response = 4'd5; mem2proc_tag = 4'd5; mem2proc_data = 64'h77;
    cyc();
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
    vectors++;
    if (ld_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || resp_data !== 64'h77) begin
      miscompares++;
      $display("FAIL same_tag_old_owner: ld_v=%b if_v=%b data=%h, want 1 0 77", ld_resp_valid, if_resp_valid, resp_data);
    end
    for (int i = 0; i < 7; i++) begin
      do_load(1'b0, 32'h3000 + 32'(i), tags[i], got);
      vectors++;
      if (got !== 1'b1) begin
        miscompares++;
        $display("FAIL same_tag_count_fill_%0d: grant=%b, want 1", i, got);
      end
    end
    do_load(1'b0, 32'h3100, 4'd9, got);
    vectors++;
    if (got !== 1'b0) begin
      miscompares++;
      $display("FAIL same_tag_count_full: grant=%b, want 0", got);
    end
    mem2proc_tag = 4'd5; mem2proc_data = 64'h55;
    cyc();
    mem2proc_tag = 4'd0;
    vectors++;
    if (if_resp_valid !== 1'b1 || ld_resp_valid !== 1'b0 || resp_data !== 64'h55) begin
      miscompares++;
      $display("FAIL same_tag_new_entry: if_v=%b ld_v=%b data=%h, want 1 0 55", if_resp_valid, ld_resp_valid, resp_data);
    end
  endtask

  task automatic test_starvation();
    bit exp_if;
    apply_reset();
    ld_req = 1'b1; ld_addr = 32'h500;
    if_req = 1'b1; if_addr = 32'h600;
    for (int d = 1; d <= 6; d++) begin
`ifdef MEM_ARB_STARVE_EN
      exp_if = (d == 5);
`else
      exp_if = 1'b0;
`endif
      cyc();
      vectors++;
      if (if_grant !== exp_if || ld_grant !== !exp_if) begin
        miscompares++;
        $display("FAIL starve_decision_%0d: ld_grant=%b if_grant=%b, want %b %b", d, ld_grant, if_grant, !exp_if, exp_if);
      end
      mem2proc_response = 4'(d);
      cyc();
      mem2proc_response = 4'd0;
    end
    ld_req = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    bit got;
    apply_reset();
    for (int i = 1; i <= 3; i++) do_load(1'b0, 32'h700 + 32'(i), 4'(i), got);
    ld_req = 1'b1; ld_addr = 32'h7F0;
    cyc();
    vectors++;
    if (ld_grant !== 1'b1 || ex_rd_mem !== 1'b1 || proc2mem_command !== 2'd1) begin
      miscompares++;
      $display("FAIL rst_mid_issue_pre: grant=%b rd=%b cmd=%0d, want 1 1 1", ld_grant, ex_rd_mem, proc2mem_command);
    end
    ld_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (proc2mem_command !== 2'd0 || ex_rd_mem !== 1'b0 || ld_grant !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async_clear: cmd=%0d rd=%b grant=%b, want 0 0 0", proc2mem_command, ex_rd_mem, ld_grant);
    end
    cyc();
    reset = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      mem2proc_tag = 4'(t); mem2proc_data = 64'hF0 + 64'(t);
      cyc();
      vectors++;
      if (ld_resp_valid !== 1'b0 || if_resp_valid !== 1'b0 || proc2mem_command !== 2'd0 || resp_data !== 64'd0) begin
        miscompares++;
        $display("FAIL rst_stale_tag_%0d: ld_v=%b if_v=%b cmd=%0d data=%h, want 0 0 0 0",
                 t, ld_resp_valid, if_resp_valid, proc2mem_command, resp_data);
      end
    end
    mem2proc_tag = 4'd0;
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_priority();
    test_outstanding_limit();
    test_same_tag_accept_return();
    test_starvation();
    test_reset_in_flight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
